// File: rtl/fft_bfly_scheduler.sv
// fft_bfly_scheduler: sequences butterfly reads, twiddles and write-backs for an in-place radix-2 DIF FFT
module fft_bfly_scheduler #(
    parameter int N        = 64,
    parameter int PIPE_LAT = 2,
    parameter int AW       = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2($clog2(N)):0]    stage,
    output logic                          rd_valid,
    output logic [AW-1:0]                 rd_addr0,
    output logic [AW-1:0]                 rd_addr1,
    output logic [AW-2:0]                 tw_idx,
    output logic                          wr_en,
    output logic [AW-1:0]                 wr_addr0,
    output logic [AW-1:0]                 wr_addr1
);
    localparam int LOG2N = $clog2(N);
    localparam int SW    = $clog2(LOG2N) + 1;
    localparam int BW    = LOG2N - 1;
    localparam int CW    = $clog2(PIPE_LAT) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    logic [BW-1:0] b;
    logic [CW-1:0] cnt;
    logic [BW-1:0] nb;
    logic [SW-1:0] nst;
    logic [AW-1:0] bx, half, msk, nk, na0, na1;
    logic [AW-2:0] ntw;
    logic          vp [PIPE_LAT];
    logic [AW-1:0] p0 [PIPE_LAT];
    logic [AW-1:0] p1 [PIPE_LAT];

    // addresses of the butterfly issued next cycle; low bits of b are k, high bits are g
    always_comb begin
        nb   = (state == RUN) ? b + BW'(1) : '0;
        nst  = (state == DRAIN) ? stage + SW'(1) : (state == IDLE) ? '0 : stage;
        bx   = AW'(nb);
        half = AW'(N / 2) >> nst;
        msk  = half - AW'(1);
        nk   = bx & msk;
        na0  = ((bx & ~msk) << 1) | nk;
        na1  = na0 | half;
        ntw  = (AW-1)'(nk << nst);
    end

    // control FSM with registered read-side outputs; addresses hold while idle or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            stage    <= '0;
            b        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_idx   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    stage    <= '0;
                    b        <= '0;
                    busy     <= 1'b1;
                    rd_valid <= 1'b1;
                    rd_addr0 <= na0;
                    rd_addr1 <= na1;
                    tw_idx   <= ntw;
                end
                RUN: if (b == BW'(N / 2 - 1)) begin
                    state    <= DRAIN;
                    b        <= '0;
                    cnt      <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    b        <= nb;
                    rd_addr0 <= na0;
                    rd_addr1 <= na1;
                    tw_idx   <= ntw;
                end
                DRAIN: if (cnt == CW'(PIPE_LAT - 1)) begin
                    if (stage == SW'(LOG2N - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= RUN;
                        stage    <= nst;
                        rd_valid <= 1'b1;
                        rd_addr0 <= na0;
                        rd_addr1 <= na1;
                        tw_idx   <= ntw;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // write-back shift pipeline: read strobe and addresses delayed by PIPE_LAT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                vp[i] <= 1'b0;
                p0[i] <= '0;
                p1[i] <= '0;
            end
        end else begin
            vp[0] <= rd_valid;
            p0[0] <= rd_addr0;
            p1[0] <= rd_addr1;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vp[i] <= vp[i-1];
                p0[i] <= p0[i-1];
                p1[i] <= p1[i-1];
            end
        end
    end

    assign wr_en    = vp[PIPE_LAT-1];
    assign wr_addr0 = p0[PIPE_LAT-1];
    assign wr_addr1 = p1[PIPE_LAT-1];
endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// tb_fft_bfly_scheduler: random start/reset stimulus checked against a cycle-indexed schedule model
module tb_fft_bfly_scheduler;
    localparam int N     = 8;
    localparam int PL    = 2;
    localparam int LOG2N = $clog2(N);
    localparam int AW    = LOG2N;
    localparam int SW    = $clog2(LOG2N) + 1;
    localparam int L     = LOG2N * (N / 2 + PL) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, rd_valid, wr_en;
    logic [SW-1:0] stage;
    logic [AW-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [AW-2:0] tw_idx;

    fft_bfly_scheduler #(.N(N), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .stage(stage),
        .rd_valid(rd_valid), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int c;
    int e_busy, e_done, e_stage, e_rv, e_a0, e_a1, e_tw, e_we, e_w0, e_w1;
    int qv[$], qa0[$], qa1[$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_outs(input string p);
        check({p, ".busy"}, int'(busy), e_busy);
        check({p, ".done"}, int'(done), e_done);
        check({p, ".stage"}, int'(stage), e_stage);
        check({p, ".rd_valid"}, int'(rd_valid), e_rv);
        check({p, ".rd_addr0"}, int'(rd_addr0), e_a0);
        check({p, ".rd_addr1"}, int'(rd_addr1), e_a1);
        check({p, ".tw_idx"}, int'(tw_idx), e_tw);
        check({p, ".wr_en"}, int'(wr_en), e_we);
        check({p, ".wr_addr0"}, int'(wr_addr0), e_w0);
        check({p, ".wr_addr1"}, int'(wr_addr1), e_w1);
    endtask

    task automatic model_reset();
        c = 0;
        {e_busy, e_done, e_stage, e_rv, e_a0, e_a1, e_tw, e_we, e_w0, e_w1} = '0;
        qv.delete();
        qa0.delete();
        qa1.delete();
        repeat (PL) begin
            qv.push_back(0);
            qa0.push_back(0);
            qa1.push_back(0);
        end
    endtask

    // c counts cycles since the accepted start; each stage is N/2 reads followed by PL idle cycles
    task automatic model_step(input int st);
        int s, r, half, k, g, idx;
        if (c == 0) c = st ? 1 : 0;
        else c = (c == L) ? 0 : c + 1;
        e_busy = (c > 0);
        e_done = (c == L);
        e_rv = 0;
        if (c >= 1 && c < L) begin
            s = (c - 1) / (N / 2 + PL);
            r = (c - 1) % (N / 2 + PL);
            e_stage = s;
            if (r < N / 2) begin
                half = N >> (s + 1);
                k = r % half;
                g = r / half;
                e_rv = 1;
                e_a0 = 2 * half * g + k;
                e_a1 = e_a0 + half;
                e_tw = k * (1 << s);
            end
        end
        qv.push_back(e_rv);
        qa0.push_back(e_a0);
        qa1.push_back(e_a1);
        idx = qv.size() - 1 - PL;
        e_we = qv[idx];
        e_w0 = qa0[idx];
        e_w1 = qa1[idx];
    endtask

    initial begin
        int st;
        bit r1 = 0;
        rst_n = 1'b0;
        start = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outs("reset");
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            st = (cyc >= 400 && cyc < 460) ? 1 : int'($urandom_range(0, 3) == 0);
            start = st[0];
            @(negedge clk);
            model_step(st);
            check_outs("run");
            if ((!r1 && cyc > 300 && c == 9) || cyc == 1000 + int'($urandom_range(0, 1))) begin
                r1 = 1;
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outs("async_rst");
                @(negedge clk);
                check_outs("rst_hold");
                rst_n = 1'b1;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
